// File: rtl/integ_dump_decim.sv
// integ_dump_decim: multi-channel integrate-and-dump decimator.
// Counts its own decimation periods, normalises each dump by clog2(rate)
// less a programmable gain, and saturates to BW bits.
// Optional build macro INTEG_DUMP_ROUND_EN: round half up before the
// normalising shift instead of truncating.
module integ_dump_decim #(
  parameter int BW         = 16,
  parameter int MAXBITGAIN = 8,
  parameter int NCHAN      = 2,
  parameter int RATE_W     = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [RATE_W-1:0]     rate,
  input  logic [3:0]            gain,
  input  logic                  strobe_in,
  input  logic [NCHAN*BW-1:0]   signal_in,
  output logic                  strobe_out,
  output logic [NCHAN*BW-1:0]   signal_out,
  output logic [NCHAN-1:0]      sat_flag
);

  localparam int AW = BW + MAXBITGAIN;
  localparam int SW = 8;

  localparam logic [RATE_W-1:0]     RATE_ONE  = {{(RATE_W-1){1'b0}}, 1'b1};
  localparam logic [RATE_W-1:0]     RATE_ZERO = {RATE_W{1'b0}};
  localparam logic [SW-1:0]         SHIFT_ZERO = {SW{1'b0}};
  localparam logic signed [AW:0]    SAT_MAX   = {{(AW-BW+2){1'b0}}, {(BW-1){1'b1}}};
  localparam logic signed [AW:0]    SAT_MIN   = {{(AW-BW+2){1'b1}}, {(BW-1){1'b0}}};
  localparam logic [BW-1:0]         SAT_MAX_N = {1'b0, {(BW-1){1'b1}}};
  localparam logic [BW-1:0]         SAT_MIN_N = {1'b1, {(BW-1){1'b0}}};
`ifdef INTEG_DUMP_ROUND_EN
  localparam logic [SW-1:0]         SHIFT_ONE = {{(SW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]           HALF_BASE = {{AW{1'b0}}, 1'b1};
`endif

  // Ceiling log2 of a non-zero period length; clog2(1) = 0.
  function automatic logic [SW-1:0] clog2_f(input logic [RATE_W-1:0] v);
    logic [RATE_W-1:0] m;
    logic [SW-1:0]     n;
    m = v - RATE_ONE;
    n = SHIFT_ZERO;
    for (int i = 0; i < RATE_W; i++) begin
      if (m[i]) n = SW'(i + 1);
      else      n = n;
    end
    return n;
  endfunction

  logic                     clear_s;
  logic                     start_r;
  logic [RATE_W-1:0]        reff_r;
  logic [3:0]               g_r;
  logic [RATE_W-1:0]        count_r;
  logic [RATE_W-1:0]        rate_eff_s;
  logic [RATE_W-1:0]        cur_reff_s;
  logic [3:0]               cur_g_s;
  logic [RATE_W-1:0]        cur_count_s;
  logic                     dump_now_s;
  logic [SW-1:0]            lg_s;
  logic [SW-1:0]            shift_s;
  logic signed [AW-1:0]     in_ext_s   [NCHAN];
  logic signed [AW-1:0]     accum_r    [NCHAN];
  logic signed [AW-1:0]     dump_r     [NCHAN];
  logic                     v1_r;
  logic [SW-1:0]            s1_r;
  logic signed [AW:0]       pre_s      [NCHAN];
  logic signed [AW:0]       norm_s     [NCHAN];
  logic signed [AW:0]       shifted_r  [NCHAN];
  logic                     v2_r;
  logic [BW-1:0]            sat_val_s  [NCHAN];
  logic [NCHAN-1:0]         sat_s;

  // Period parameters: fresh from the ports on the first clock after a clear,
  // otherwise the values latched at the last period start.
  always_comb begin
    clear_s    = reset | ~enable;
    rate_eff_s = (rate == RATE_ZERO) ? RATE_ONE : rate;
    if (start_r) begin
      cur_reff_s  = rate_eff_s;
      cur_g_s     = gain;
      cur_count_s = rate_eff_s - RATE_ONE;
    end else begin
      cur_reff_s  = reff_r;
      cur_g_s     = g_r;
      cur_count_s = count_r;
    end
    dump_now_s = strobe_in & (cur_count_s == RATE_ZERO);
    lg_s       = clog2_f(cur_reff_s);
    if (lg_s > {{(SW-4){1'b0}}, cur_g_s}) shift_s = lg_s - {{(SW-4){1'b0}}, cur_g_s};
    else                                  shift_s = SHIFT_ZERO;
  end

  // Sign-extend every channel's input to accumulator width.
  always_comb begin
    for (int k = 0; k < NCHAN; k++) begin
      in_ext_s[k] = AW'($signed(signal_in[k*BW +: BW]));
    end
  end

  // Stage 1: period counter, accumulation and dump capture.
  always_ff @(posedge clock) begin
    if (clear_s) begin
      start_r <= 1'b1;
      reff_r  <= RATE_ONE;
      g_r     <= 4'd0;
      count_r <= RATE_ZERO;
      v1_r    <= 1'b0;
      s1_r    <= SHIFT_ZERO;
      for (int k = 0; k < NCHAN; k++) begin
        accum_r[k] <= {AW{1'b0}};
        dump_r[k]  <= {AW{1'b0}};
      end
    end else begin
      start_r <= 1'b0;
      v1_r    <= dump_now_s;
      if (dump_now_s) begin
        // Dump closes the period and starts the next with the live rate/gain.
        reff_r  <= rate_eff_s;
        g_r     <= gain;
        count_r <= rate_eff_s - RATE_ONE;
        s1_r    <= shift_s;
        for (int k = 0; k < NCHAN; k++) begin
          dump_r[k]  <= accum_r[k] + in_ext_s[k];
          accum_r[k] <= {AW{1'b0}};
        end
      end else if (strobe_in) begin
        reff_r  <= cur_reff_s;
        g_r     <= cur_g_s;
        count_r <= cur_count_s - RATE_ONE;
        for (int k = 0; k < NCHAN; k++) begin
          accum_r[k] <= accum_r[k] + in_ext_s[k];
        end
      end else begin
        reff_r  <= cur_reff_s;
        g_r     <= cur_g_s;
        count_r <= cur_count_s;
      end
    end
  end

  // Normalising shift of each dump, optionally rounded half up.
  always_comb begin
    for (int k = 0; k < NCHAN; k++) begin
      pre_s[k] = {dump_r[k][AW-1], dump_r[k]};
`ifdef INTEG_DUMP_ROUND_EN
      if (s1_r != SHIFT_ZERO) pre_s[k] = pre_s[k] + (HALF_BASE << (s1_r - SHIFT_ONE));
      else                    pre_s[k] = pre_s[k];
`endif
      norm_s[k] = pre_s[k] >>> s1_r;
    end
  end

  // Stage 2: register the normalised values.
  always_ff @(posedge clock) begin
    if (clear_s) begin
      v2_r <= 1'b0;
      for (int k = 0; k < NCHAN; k++) shifted_r[k] <= {(AW+1){1'b0}};
    end else begin
      v2_r <= v1_r;
      if (v1_r) begin
        for (int k = 0; k < NCHAN; k++) shifted_r[k] <= norm_s[k];
      end
    end
  end

  // Clamp each channel to the BW-bit two's complement range.
  always_comb begin
    sat_s = {NCHAN{1'b0}};
    for (int k = 0; k < NCHAN; k++) begin
      sat_val_s[k] = {BW{1'b0}};
      if (shifted_r[k] > SAT_MAX) begin
        sat_val_s[k] = SAT_MAX_N;
        sat_s[k]     = 1'b1;
      end else if (shifted_r[k] < SAT_MIN) begin
        sat_val_s[k] = SAT_MIN_N;
        sat_s[k]     = 1'b1;
      end else begin
        sat_val_s[k] = shifted_r[k][BW-1:0];
        sat_s[k]     = 1'b0;
      end
    end
  end

  // Stage 3: registered outputs, held between strobes.
  always_ff @(posedge clock) begin
    if (clear_s) begin
      strobe_out <= 1'b0;
      signal_out <= {(NCHAN*BW){1'b0}};
      sat_flag   <= {NCHAN{1'b0}};
    end else begin
      strobe_out <= v2_r;
      if (v2_r) begin
        sat_flag <= sat_s;
        for (int k = 0; k < NCHAN; k++) signal_out[k*BW +: BW] <= sat_val_s[k];
      end
    end
  end

endmodule

// File: tb/tb_integ_dump_decim.sv
// Bench for integ_dump_decim: period-level reference model plus directed
// scenarios with hand-computed expected values, then randomized traffic.
module tb_integ_dump_decim;

`ifdef INTEG_DUMP_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  rate;
  logic [3:0]  gain;
  logic        strobe_in;
  logic [31:0] signal_in;
  logic        strobe_out;
  logic [31:0] signal_out;
  logic [1:0]  sat_flag;

  always #5 clock = ~clock;

  integ_dump_decim dut (
    .clock(clock), .reset(reset), .enable(enable), .rate(rate), .gain(gain),
    .strobe_in(strobe_in), .signal_in(signal_in), .strobe_out(strobe_out),
    .signal_out(signal_out), .sat_flag(sat_flag)
  );

  typedef struct {
    int         due;
    int         v0;
    int         v1;
    logic [1:0] sat;
  } res_t;

  int   tests = 0;
  int   fails = 0;
  int   edge_n = 0;
  res_t pend_q[$];
  res_t obs_q[$];

  bit     m_open = 1'b0;
  int     m_reff, m_g, m_n;
  longint m_sum0, m_sum1;
  bit         exp_stb = 1'b0;
  int         exp_v0 = 0, exp_v1 = 0;
  logic [1:0] exp_sat = 2'b00;

  function automatic void chk(string name, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endfunction

  // Reference result of one decimation period.
  function automatic void calc(input longint sum, input int reff, input int g,
                               output int v, output bit sat);
    int     s;
    longint x;
    s = 0;
    while ((64'sd1 <<< s) < reff) s++;
    s = s - g;
    if (s < 0) s = 0;
    x = sum;
    if (RND == 1 && s > 0) x = x + (64'sd1 <<< (s - 1));
    x = x >>> s;
    sat = 1'b0;
    if (x > 32767)       begin x = 32767;  sat = 1'b1; end
    else if (x < -32768) begin x = -32768; sat = 1'b1; end
    v = int'(x);
  endfunction

  task automatic model_step(input bit rst, input bit en, input int rt, input int gn,
                            input bit stb, input int a, input int b);
    res_t r;
    bit   s0, s1;
    if (rst || !en) begin
      m_open = 1'b0;
      pend_q.delete();
      exp_stb = 1'b0; exp_v0 = 0; exp_v1 = 0; exp_sat = 2'b00;
    end else begin
      if (!m_open) begin
        m_reff = (rt == 0) ? 1 : rt; m_g = gn;
        m_n = 0; m_sum0 = 0; m_sum1 = 0; m_open = 1'b1;
      end
      if (stb) begin
        m_sum0 += a; m_sum1 += b; m_n++;
        if (m_n == m_reff) begin
          calc(m_sum0, m_reff, m_g, r.v0, s0);
          calc(m_sum1, m_reff, m_g, r.v1, s1);
          r.sat = {s1, s0};
          r.due = edge_n + 2;
          pend_q.push_back(r);
          m_n = 0; m_sum0 = 0; m_sum1 = 0;
          m_reff = (rt == 0) ? 1 : rt; m_g = gn;
        end
      end
      exp_stb = 1'b0;
      if (pend_q.size() > 0 && pend_q[0].due == edge_n) begin
        r = pend_q.pop_front();
        exp_stb = 1'b1; exp_v0 = r.v0; exp_v1 = r.v1; exp_sat = r.sat;
      end
    end
  endtask

  // One clock: drive, advance, update the model, compare every output.
  task automatic cyc(input bit rst, input bit en, input int rt, input int gn,
                     input bit stb, input int a, input int b);
    res_t o;
    reset = rst; enable = en; rate = 8'(rt); gain = 4'(gn);
    strobe_in = stb; signal_in = {16'(b), 16'(a)};
    @(posedge clock);
    edge_n++;
    model_step(rst, en, rt, gn, stb, a, b);
    #1;
    chk("strobe_out", strobe_out, exp_stb);
    chk("ch0", $signed(signal_out[15:0]), exp_v0);
    chk("ch1", $signed(signal_out[31:16]), exp_v1);
    chk("sat_flag", sat_flag, exp_sat);
    if (strobe_out) begin
      o.due = edge_n; o.v0 = $signed(signal_out[15:0]);
      o.v1 = $signed(signal_out[31:16]); o.sat = sat_flag;
      obs_q.push_back(o);
    end
  endtask

  task automatic idle(input int n, input int rt, input int gn);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, rt, gn, 1'b0, 0, 0);
  endtask

  initial begin
    int e0;
    int rt, gn, a, b;
    bit rst, en, stb;
    logic signed [15:0] t0, t1;

    // Reset state
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 4, 0, 1'b0, 0, 0);
    chk("reset_strobe", strobe_out, 0);
    chk("reset_signal", signal_out, 0);
    chk("reset_sat", sat_flag, 0);

    // Constant input, rate 4
    obs_q.delete();
    e0 = edge_n + 1;
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, 4, 0, 1'b1, 100, 100);
    idle(3, 4, 0);
    chk("const_count", obs_q.size(), 3);
    if (obs_q.size() >= 2) begin
      chk("const_first_latency", obs_q[0].due - e0, 5);
      chk("const_spacing", obs_q[1].due - obs_q[0].due, 4);
      chk("const_v0", obs_q[0].v0, 100);
      chk("const_v1", obs_q[1].v1, 100);
      chk("const_sat", obs_q[0].sat, 0);
    end

    // Rounding, rate 3
    cyc(1'b0, 1'b0, 3, 0, 1'b0, 0, 0);
    obs_q.delete();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 3, 0, 1'b1, 1, -1);
    idle(3, 3, 0);
    chk("round_count", obs_q.size(), 1);
    if (obs_q.size() >= 1) begin
      chk("round_pos", obs_q[0].v0, (RND == 1) ? 1 : 0);
      chk("round_neg", obs_q[0].v1, -1);
    end

    // Saturation, then gain back to 0
    cyc(1'b0, 1'b0, 4, 1, 1'b0, 0, 0);
    obs_q.delete();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 4, 1, 1'b1, 20000, -20000);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 4, 0, 1'b1, 20000, -20000);
    idle(3, 4, 0);
    chk("sat_count", obs_q.size(), 2);
    if (obs_q.size() >= 2) begin
      chk("sat_hi", obs_q[0].v0, 32767);
      chk("sat_lo", obs_q[0].v1, -32768);
      chk("sat_flags", obs_q[0].sat, 3);
      chk("unsat_v0", obs_q[1].v0, 20000);
      chk("unsat_v1", obs_q[1].v1, -20000);
      chk("unsat_flags", obs_q[1].sat, 0);
    end

    // Rate change mid-period: 2 then 5
    cyc(1'b0, 1'b0, 2, 0, 1'b0, 0, 0);
    obs_q.delete();
    cyc(1'b0, 1'b1, 2, 0, 1'b1, 10, 10);
    cyc(1'b0, 1'b1, 5, 0, 1'b1, 20, 20);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 5, 0, 1'b1, 8, 8);
    idle(3, 5, 0);
    chk("ratechg_count", obs_q.size(), 2);
    if (obs_q.size() >= 2) begin
      chk("ratechg_first", obs_q[0].v0, 15);
      chk("ratechg_second", obs_q[1].v1, 5);
      chk("ratechg_spacing", obs_q[1].due - obs_q[0].due, 5);
    end

    // Reset one clock after a dump
    cyc(1'b0, 1'b0, 3, 0, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 3, 0, 1'b1, 7, 7);
    cyc(1'b1, 1'b1, 3, 0, 1'b0, 0, 0);
    chk("rstmid_strobe0", strobe_out, 0);
    chk("rstmid_signal0", signal_out, 0);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b1, 3, 0, 1'b0, 0, 0);
      chk("rstmid_strobe", strobe_out, 0);
      chk("rstmid_signal", signal_out, 0);
    end
    obs_q.delete();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 3, 0, 1'b1, 7, 7);
    e0 = edge_n;
    idle(3, 3, 0);
    chk("rstmid_after_count", obs_q.size(), 1);
    if (obs_q.size() >= 1) begin
      chk("rstmid_after_val", obs_q[0].v0, 5);
      chk("rstmid_after_lat", obs_q[0].due - e0, 2);
    end

    // Rate 0 and rate 1 pass-through, gain 15 irrelevant
    for (int r = 0; r < 2; r++) begin
      cyc(1'b0, 1'b0, r, 15, 1'b0, 0, 0);
      obs_q.delete();
      e0 = edge_n + 1;
      cyc(1'b0, 1'b1, r, 15, 1'b1, 5, -5);
      cyc(1'b0, 1'b1, r, 15, 1'b1, -7, 7);
      cyc(1'b0, 1'b1, r, 15, 1'b1, 9, -9);
      idle(3, r, 15);
      chk("pass_count", obs_q.size(), 3);
      if (obs_q.size() >= 3) begin
        chk("pass_v0a", obs_q[0].v0, 5);
        chk("pass_v0b", obs_q[1].v0, -7);
        chk("pass_v0c", obs_q[2].v0, 9);
        chk("pass_v1b", obs_q[1].v1, 7);
        chk("pass_lat", obs_q[0].due - e0, 2);
      end
    end

    // Randomized traffic with gaps, rate/gain changes, clears
    rt = 3; gn = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3)  rt = $urandom_range(0, 12);
      if ($urandom_range(0, 199) < 1) rt = $urandom_range(200, 255);
      if ($urandom_range(0, 99) < 3)  gn = $urandom_range(0, 15);
      rst = ($urandom_range(0, 199) == 0);
      en  = ($urandom_range(0, 199) != 0);
      stb = ($urandom_range(0, 99) < 60);
      t0 = 16'($urandom);
      t1 = 16'($urandom);
      if ($urandom_range(0, 3) == 0) t0 = t0 >>> 8;
      a = t0; b = t1;
      cyc(rst, en, rt, gn, stb, a, b);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
